line_burst_responder: RTL and testbench

LINE_BURST_RESPONDER -- requirements
Module: line_burst_responder

---
 rtl/lc3b_types.sv | 16 +
 rtl/line_burst_responder.sv | 101 ++++++++++
 tb/tb_line_burst_responder.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/lc3b_types.sv
// rtl/lc3b_types.sv - shared LC-3b word/line types and line burst responder state encoding
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_l1_line;

  localparam int BEATS_PER_LINE = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BEAT = 2'd1,
    WR_BEAT = 2'd2,
    RESP    = 2'd3
  } lc3b_lbr_state_t;

endpackage

// File: rtl/line_burst_responder.sv
// rtl/line_burst_responder.sv - serves one 128-bit L2 line request as 8 sequential 16-bit pmem beats
module line_burst_responder
  import lc3b_types::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  lc3b_word    l2cache_address,
  input  lc3b_l1_line l2cache_wdata,
  output lc3b_l1_line l2cache_rdata,
  input  logic        l2_read,
  input  logic        l2_write,
  output logic        l2_resp,
  output lc3b_word    pmem_address,
  output lc3b_word    pmem_wdata,
  input  lc3b_word    pmem_rdata,
  output logic        pmem_read,
  output logic        pmem_write,
  input  logic        pmem_resp
);

  localparam logic [2:0] LAST_BEAT = 3'(BEATS_PER_LINE - 1);

  lc3b_lbr_state_t state, state_next;
  logic [2:0]      k, k_next;
  lc3b_word        base;
  lc3b_l1_line     wline;
  lc3b_l1_line     rline;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      k     <= 3'd0;
      base  <= '0;
      wline <= '0;
      rline <= '0;
    end else begin
      state <= state_next;
      k     <= k_next;
      if (state == IDLE && l2_write) begin
        base  <= l2cache_address & 16'hFFF0;
        wline <= l2cache_wdata;
      end else if (state == IDLE && l2_read) begin
        base  <= l2cache_address & 16'hFFF0;
      end
      // Read beats land directly in the output line, so rdata holds until the next read's beat 0.
      if (state == RD_BEAT && pmem_resp) begin
        rline[{k, 4'b0000} +: 16] <= pmem_rdata;
      end
    end
  end

  always_comb begin
    state_next = state;
    k_next     = k;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    l2_resp    = 1'b0;
    case (state)
      IDLE: begin
        if (l2_write) begin
          state_next = WR_BEAT;
          k_next     = 3'd0;
        end else if (l2_read) begin
          state_next = RD_BEAT;
          k_next     = 3'd0;
        end
      end
      RD_BEAT: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          k_next = k + 3'd1;
          if (k == LAST_BEAT) state_next = RESP;
        end
      end
      WR_BEAT: begin
        pmem_write = 1'b1;
        if (pmem_resp) begin
          k_next = k + 3'd1;
          if (k == LAST_BEAT) state_next = RESP;
        end
      end
      RESP: begin
        l2_resp    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Outputs are forced quiet while reset is held so nothing leaks out before the first edge.
    if (!reset_n) begin
      pmem_read  = 1'b0;
      pmem_write = 1'b0;
      l2_resp    = 1'b0;
    end
  end

  // Base has bits [3:0] clear, so OR-ing the beat offset can never carry into bit 4.
  assign pmem_address  = reset_n ? (base | {12'h000, k, 1'b0}) : 16'h0000;
  assign pmem_wdata    = wline[{k, 4'b0000} +: 16];
  assign l2cache_rdata = rline;

endmodule

// File: tb/tb_line_burst_responder.sv
// tb/tb_line_burst_responder.sv - scoreboard bench for line_burst_responder with a pmem responder model
module tb_line_burst_responder;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [15:0]  l2cache_address;
  logic [127:0] l2cache_wdata;
  logic [127:0] l2cache_rdata;
  logic         l2_read, l2_write, l2_resp;
  logic [15:0]  pmem_address, pmem_wdata, pmem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;

  always #5 clk = ~clk;

  line_burst_responder dut (
    .clk(clk), .reset_n(reset_n),
    .l2cache_address(l2cache_address), .l2cache_wdata(l2cache_wdata),
    .l2cache_rdata(l2cache_rdata), .l2_read(l2_read), .l2_write(l2_write),
    .l2_resp(l2_resp), .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp)
  );

  typedef struct { logic [15:0] addr; logic wr; logic [15:0] wdata; } beat_t;
  typedef struct { logic [127:0] rdata; int lat; } resp_t;

  beat_t        exp_beats[$];
  resp_t        exp_resps[$];
  logic [15:0]  pmem_mem [0:32767];
  logic [15:0]  ref_mem  [0:32767];
  logic [127:0] last_rd;
  int n_cmp = 0, n_fail = 0, n_resp = 0, n_req = 0;
  int cyc = 0, issue_cyc = 0;
  int mode_lat = 0, wait_cnt = 0, cur_lat = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // pmem model: mode_lat waiting cycles per beat (-1 = random 0..3); zero-wait ties resp high.
  always @(negedge clk) begin
    if (pmem_read || pmem_write) begin
      if (wait_cnt >= cur_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = pmem_mem[pmem_address[15:1]];
        if (pmem_write) pmem_mem[pmem_address[15:1]] = pmem_wdata;
        wait_cnt = 0;
        cur_lat  = (mode_lat < 0) ? int'($urandom_range(0, 3)) : mode_lat;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = 16'hDEAD;
        wait_cnt++;
      end
    end else begin
      pmem_resp  = (mode_lat == 0);
      pmem_rdata = 16'hBEEF;
      wait_cnt   = 0;
      cur_lat    = (mode_lat < 0) ? int'($urandom_range(0, 3)) : mode_lat;
    end
  end

  // Monitor: pops the scoreboard on every completed beat and every l2_resp.
  always @(negedge clk) begin
    beat_t b;
    resp_t r;
    #1;
    if (pmem_read && pmem_write) check("strobe_exclusive", 1, 0);
    if ((pmem_read || pmem_write) && pmem_resp) begin
      if (exp_beats.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_beat: got addr %h wr %0d expected no beat", pmem_address, pmem_write);
      end else begin
        b = exp_beats.pop_front();
        check("beat_addr", pmem_address, b.addr);
        check("beat_dir", pmem_write, b.wr);
        if (b.wr) check("beat_wdata", pmem_wdata, b.wdata);
      end
    end
    if (l2_resp) begin
      n_resp++;
      check("resp_strobes", {pmem_read, pmem_write}, 0);
      if (exp_resps.size() == 0) begin
        n_cmp++; n_fail++;
        $display("FAIL unexpected_resp: got l2_resp 1 expected 0");
      end else begin
        r = exp_resps.pop_front();
        check("resp_rdata", l2cache_rdata, r.rdata);
        if (r.lat >= 0) check("resp_latency", cyc - issue_cyc, r.lat);
      end
    end
  end

  task automatic push_line(input logic [15:0] addr, input logic wr, input logic [127:0] wd, input int lat);
    logic [15:0] base;
    base = addr & 16'hFFF0;
    for (int k = 0; k < 8; k++) begin
      exp_beats.push_back(beat_t'{base + 16'(2 * k), wr, wd[16*k +: 16]});
      if (wr) ref_mem[base[15:1] + 15'(k)] = wd[16*k +: 16];
      else    last_rd[16*k +: 16] = ref_mem[base[15:1] + 15'(k)];
    end
    exp_resps.push_back(resp_t'{last_rd, lat});
    n_req++;
  endtask

  task automatic wait_resp(input int budget);
    int n = 0;
    do begin
      @(negedge clk); #1;
      n++;
    end while (!l2_resp && n < budget);
    if (!l2_resp) begin
      n_cmp++; n_fail++;
      $display("FAIL resp_timeout: got no l2_resp expected one within %0d cycles", budget);
    end
  endtask

  task automatic request(input logic [15:0] addr, input logic rd, input logic wr,
                         input logic [127:0] wd, input int lat, input int hold_extra);
    @(negedge clk); #2;
    push_line(addr, wr, wd, lat);
    if (hold_extra >= 2) push_line(addr, wr, wd, -1);
    issue_cyc = cyc;
    l2cache_address = addr; l2cache_wdata = wd; l2_read = rd; l2_write = wr;
    if (hold_extra < 2) begin
      @(negedge clk); #2;
      l2cache_address = ~addr; l2cache_wdata = ~wd;
    end
    wait_resp(300);
    for (int i = 0; i < hold_extra; i++) @(negedge clk);
    #1;
    l2_read = 1'b0; l2_write = 1'b0;
    if (hold_extra >= 2) wait_resp(300);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    logic [15:0]  a;
    logic [127:0] wd;
    int           op;
    for (int i = 0; i < 32768; i++) begin
      pmem_mem[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i]  = 16'(i) ^ 16'h5A5A;
    end
    for (int k = 0; k < 8; k++) begin
      pmem_mem[15'h0918 + 15'(k)] = 16'hA000 + 16'(k);
      ref_mem[15'h0918 + 15'(k)]  = 16'hA000 + 16'(k);
    end
    last_rd = '0;
    reset_n = 1'b0; l2_read = 1'b0; l2_write = 1'b0;
    l2cache_address = 16'h0; l2cache_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = 16'h0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_l2_resp", l2_resp, 0);
    check("reset_strobes", {pmem_read, pmem_write}, 0);
    check("reset_address", pmem_address, 0);
    check("reset_rdata", l2cache_rdata, 0);
    #1 reset_n = 1'b1;

    // zero-wait read of line 0x1230
    mode_lat = 0;
    request(16'h1236, 1'b1, 1'b0, '0, 9, 0);
    check("read_line_const", l2cache_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // two-cycle latency write to line 0x0040
    mode_lat = 2;
    request(16'h0040, 1'b0, 1'b1, 128'h0007_0006_0005_0004_0003_0002_0001_0000, -1, 0);
    for (int k = 0; k < 8; k++) check("write_mem", pmem_mem[15'h0020 + 15'(k)], 16'(k));

    // both requests high: write wins, rdata untouched
    mode_lat = 0;
    request(16'h1230, 1'b1, 1'b1, 128'h1111_2222_3333_4444_5555_6666_7777_8888, -1, 0);
    check("both_rdata_kept", l2cache_rdata, 128'hA007_A006_A005_A004_A003_A002_A001_A000);

    // reset during beat 4 of a read
    @(negedge clk); #2;
    for (int k = 0; k < 5; k++) exp_beats.push_back(beat_t'{16'h0040 + 16'(2 * k), 1'b0, 16'h0});
    l2cache_address = 16'h0048; l2_read = 1'b1;
    repeat (5) @(negedge clk);
    #2;
    reset_n = 1'b0; l2_read = 1'b0;
    @(negedge clk); #1;
    check("abort_strobes", {pmem_read, pmem_write}, 0);
    check("abort_l2_resp", l2_resp, 0);
    check("abort_address", pmem_address, 0);
    check("abort_rdata", l2cache_rdata, 0);
    check("abort_beats_used", exp_beats.size(), 0);
    #1 reset_n = 1'b1;
    last_rd = '0;
    repeat (3) @(negedge clk);

    request(16'h004C, 1'b1, 1'b0, '0, 9, 0);
    check("post_abort_rdata", l2cache_rdata, 128'h0007_0006_0005_0004_0003_0002_0001_0000);

    // request held past l2_resp: one extra cycle is ignored, two extra re-serves
    request(16'h1230, 1'b1, 1'b0, '0, -1, 1);
    request(16'h1230, 1'b1, 1'b0, '0, -1, 2);

    // mixed traffic with random stalls
    mode_lat = -1;
    for (int i = 0; i < 200; i++) begin
      a  = 16'h2000 | 16'($urandom_range(0, 16'h01FF));
      wd = {$urandom, $urandom, $urandom, $urandom};
      op = int'($urandom_range(0, 3));
      request(a, op != 2, op >= 2, wd, -1, 0);
    end
    repeat (5) @(negedge clk);
    #1;
    check("resp_count", n_resp, n_req);
    check("beats_drained", exp_beats.size(), 0);
    check("resps_drained", exp_resps.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
